// File: rtl/tx_packet_sender.sv
// RS232 transmitter for host-link response packets: STX, addr, 4 data bytes,
// XOR checksum, ETX, each sent as an 8N1 frame with no inter-frame gap.
module tx_packet_sender #(
  parameter int unsigned CLKS_PER_BIT = 47,
  parameter logic [7:0]  STX          = 8'h02,
  parameter logic [7:0]  ETX          = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [6:0]  tx_addr,
  input  logic [31:0] tx_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned PKT_W    = 64;
  localparam int unsigned BYTE_W   = 8;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    byte_q, byte_d;
  logic [PKT_W-1:0]    packet_q, packet_d;
  logic                tx_d, busy_d, done_d;

  logic                baud_wrap;
  logic [CNT_W-1:0]    bit_nxt;
  logic [BYTE_W-1:0]   cur_byte;
  logic [BYTE_W-1:0]   addr_byte;
  logic [BYTE_W-1:0]   checksum;
  logic [PKT_W-1:0]    new_packet;

  // Packet image with byte0 in the least significant byte.
  assign addr_byte  = {1'b0, tx_addr};
  assign checksum   = addr_byte ^ tx_data[7:0] ^ tx_data[15:8]
                    ^ tx_data[23:16] ^ tx_data[31:24];
  assign new_packet = {ETX, checksum, tx_data, addr_byte, STX};

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign bit_nxt   = bit_q + CNT_W'(1);
  assign cur_byte  = packet_q[{byte_q, 3'b000} +: BYTE_W];

  // State and datapath registers; outputs are registered copies of their next values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      packet_q <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      packet_q <= packet_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    packet_d = packet_q;
    tx_d     = 1'b1;
    busy_d   = busy;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (tx_start) begin
          state_d  = S_START;
          packet_d = new_packet;
          baud_d   = '0;
          bit_d    = '0;
          byte_d   = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end

      S_START: begin
        tx_d = 1'b0;
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_wrap) begin
          baud_d = '0;
          if (byte_q == LAST_BYTE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + CNT_W'(1);
            bit_d   = '0;
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DONE: begin
        // busy stays high through the done cycle, so requests here are ignored.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_packet_sender.sv
// Bench for tx_packet_sender: a sampling UART receiver decodes the line and
// compares packets, bit timing, busy and done against a byte-level model.
`timescale 1ns/1ps
module tb_tx_packet_sender;

  localparam int C       = 47;
  localparam int H       = C / 2;
  localparam int PKT_CYC = 80 * C;
  localparam int LOG_N   = PKT_CYC + 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [6:0]  tx_addr;
  logic [31:0] tx_data;
  logic        tx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic       tx_log   [0:LOG_N];
  logic       busy_log [0:LOG_N];
  logic       done_log [0:LOG_N];
  logic [7:0] rx_q [$];
  int         frame_err;

  tx_packet_sender #(.CLKS_PER_BIT(C), .STX(8'h02), .ETX(8'h03)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_addr  (tx_addr),
    .tx_data  (tx_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packet: byte i of the response for (a, d).
  function automatic logic [7:0] exp_byte(input logic [6:0] a, input logic [31:0] d, input int i);
    logic [7:0] p [8];
    p[0] = 8'h02;
    p[1] = {1'b0, a};
    for (int j = 0; j < 4; j++) p[2 + j] = d[8 * j +: 8];
    p[6] = p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
    p[7] = 8'h03;
    return p[i];
  endfunction

  // UART receiver: find a start bit, sample every bit at its midpoint.
  task automatic decode_log();
    int idx;
    int mid;
    logic [7:0] b;
    rx_q.delete();
    frame_err = 0;
    idx = 1;
    while (idx + H + 9 * C <= LOG_N) begin
      if (tx_log[idx] === 1'b0) begin
        mid = idx + H;
        if (tx_log[mid] !== 1'b0) frame_err++;
        for (int k = 0; k < 8; k++) b[k] = tx_log[mid + C * (k + 1)];
        if (tx_log[mid + 9 * C] !== 1'b1) frame_err++;
        rx_q.push_back(b);
        idx = mid + 9 * C;
      end else begin
        idx++;
      end
    end
  endtask

  // Send one packet, log the line for a full packet time, and check it.
  task automatic run_packet(input logic [6:0] a, input logic [31:0] d,
                            input int hold, input int pulse_at, input string name);
    int edge_bad;
    int done_cnt;
    int done_idx;
    int busy_cnt;
    int nb;
    logic [31:0] word;
    check($sformatf("%s idle_tx", name), 64'(tx), 64'(1));
    check($sformatf("%s idle_busy", name), 64'(busy), 64'(0));
    tx_addr  = a;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= LOG_N; k++) begin
      tx_log[k]   = tx;
      busy_log[k] = busy;
      done_log[k] = done;
      tx_start = (k < hold) || (k == pulse_at);
      if (k == pulse_at) begin
        tx_addr = ~a;
        tx_data = ~d;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;

    check($sformatf("%s first_start_bit", name), 64'(tx_log[1]), 64'(0));
    edge_bad = 0;
    for (int k = 2; k <= LOG_N; k++)
      if (tx_log[k] !== tx_log[k - 1] && ((k - 1) % C) != 0) edge_bad++;
    check($sformatf("%s edge_timing", name), 64'(edge_bad), 64'(0));

    decode_log();
    check($sformatf("%s byte_count", name), 64'(rx_q.size()), 64'(8));
    check($sformatf("%s frame_err", name), 64'(frame_err), 64'(0));
    nb = (rx_q.size() < 8) ? rx_q.size() : 8;
    for (int i = 0; i < nb; i++)
      check($sformatf("%s byte%0d", name, i), 64'(rx_q[i]), 64'(exp_byte(a, d, i)));
    if (rx_q.size() >= 6) begin
      word = {rx_q[5], rx_q[4], rx_q[3], rx_q[2]};
      check($sformatf("%s loop_addr", name), 64'(rx_q[1][6:0]), 64'(a));
      check($sformatf("%s loop_data", name), 64'(word), 64'(d));
    end

    done_cnt = 0;
    done_idx = -1;
    busy_cnt = 0;
    for (int k = 1; k <= LOG_N; k++) begin
      if (done_log[k] === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = k;
      end
      if (k <= PKT_CYC + 1 && busy_log[k] === 1'b1) busy_cnt++;
    end
    check($sformatf("%s done_count", name), 64'(done_cnt), 64'(1));
    check($sformatf("%s done_cycle", name), 64'(done_idx), 64'(PKT_CYC + 1));
    check($sformatf("%s busy_span", name), 64'(busy_cnt), 64'(PKT_CYC + 1));
    check($sformatf("%s busy_release", name), 64'(busy_log[PKT_CYC + 2]), 64'(0));
  endtask

  initial begin
    int bad;
    int cyc;
    logic [6:0]  ra;
    logic [31:0] rd;

    rst      = 1'b1;
    tx_start = 1'b0;
    tx_addr  = '0;
    tx_data  = '0;
    tx_log[0]   = 1'b1;
    busy_log[0] = 1'b0;
    done_log[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", 64'(tx), 64'(1));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    rst = 1'b0;

    // Quiet line for 200 cycles.
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_200 deviations", 64'(bad), 64'(0));

    run_packet(7'h40, 32'hDEADBEEF, 1, 0, "deadbeef");

    for (int r = 0; r < 3; r++) begin
      ra = 7'($urandom);
      rd = $urandom;
      run_packet(ra, rd, 1 + int'($urandom_range(0, 3)), 0, $sformatf("rand%0d", r));
    end

    ra = 7'($urandom);
    rd = $urandom;
    run_packet(ra, rd, 1, 1000, "ignore_at_1000");
    run_packet(7'h7F, 32'hFFFF_FFFF, 1, PKT_CYC + 1, "ignore_in_done");

    // Reset in the middle of a packet (cycle 500 is byte1's start bit).
    tx_addr  = 7'h2A;
    tx_data  = $urandom;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (499) @(negedge clk);
    check("midrst tx_before", 64'(tx), 64'(0));
    check("midrst busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst tx", 64'(tx), 64'(1));
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 3 * C; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midrst quiet", 64'(bad), 64'(0));

    // Request coincident with reset is dropped, not queued.
    rst      = 1'b1;
    tx_start = 1'b1;
    @(negedge clk);
    check("rst_and_start busy", 64'(busy), 64'(0));
    check("rst_and_start tx", 64'(tx), 64'(1));
    rst      = 1'b0;
    tx_start = 1'b0;
    @(negedge clk);
    check("rst_and_start dropped", 64'(busy), 64'(0));

    run_packet(7'h05, 32'h0000_0000, 1, 0, "fresh05");

    // Back-to-back: a request on the cycle after done is accepted.
    tx_addr  = 7'h11;
    tx_data  = $urandom;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < PKT_CYC + 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b done_cycle", 64'(cyc), 64'(PKT_CYC + 1));
    @(negedge clk);
    check("b2b busy_low", 64'(busy), 64'(0));
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b accepted busy", 64'(busy), 64'(1));
    check("b2b accepted tx", 64'(tx), 64'(0));
    cyc = 1;
    while (done !== 1'b1 && cyc < PKT_CYC + 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b second_done", 64'(cyc), 64'(PKT_CYC + 1));
    repeat (2) @(negedge clk);
    check("b2b final_busy", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
